// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage.
//   - Default datapath widths (XLEN, register index, ALU opcode)
//   - ALU opcode encodings
//   - Operand-select encodings for the A and B muxes
//   - Saturating 32-bit increment used by the stall counter
// Optional feature macro used by importers: OPERAND_FORWARDING_EN.
package alu_operand_stage_pkg;

  localparam int unsigned DefXlen     = 32;
  localparam int unsigned DefRegAddrW = 5;
  localparam int unsigned DefAluOpW   = 4;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9
  } alu_op_e;

  localparam logic OpSelARs1 = 1'b0;
  localparam logic OpSelAPc  = 1'b1;
  localparam logic OpSelBRs2 = 1'b0;
  localparam logic OpSelBImm = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/alu_operand_stage_operand_forward_mux.sv
// operand_forward_mux: combinational source-operand resolver for one register source.
// Ports:
//   i_rs_addr, i_rf_data                       source index and register-file read data
//   i_exmem_rd_we/_addr/_data                  EX/MEM writeback candidate
//   i_memwb_rd_we/_addr/_data                  MEM/WB writeback candidate
//   o_value                                    resolved operand value
//   o_match_exmem, o_match_memwb               source matches the given producer
// Macro OPERAND_FORWARDING_EN: when defined, o_value takes EX/MEM over MEM/WB over
// the register file; otherwise o_value is the register-file data only.
// x0 never matches and always reads 0.
module operand_forward_mux
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN       = DefXlen,
  parameter int unsigned REG_ADDR_W = DefRegAddrW
) (
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic                  i_exmem_rd_we,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
  input  logic [XLEN-1:0]       i_exmem_rd_data,
  input  logic                  i_memwb_rd_we,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
  input  logic [XLEN-1:0]       i_memwb_rd_data,
  output logic [XLEN-1:0]       o_value,
  output logic                  o_match_exmem,
  output logic                  o_match_memwb
);

  logic w_rs_nonzero;

  assign w_rs_nonzero  = (i_rs_addr != '0);
  assign o_match_exmem = w_rs_nonzero & i_exmem_rd_we & (i_rs_addr == i_exmem_rd_addr);
  assign o_match_memwb = w_rs_nonzero & i_memwb_rd_we & (i_rs_addr == i_memwb_rd_addr);

`ifdef OPERAND_FORWARDING_EN
  always_comb begin
    o_value = '0;
    if (o_match_exmem) begin
      o_value = i_exmem_rd_data;
    end else if (o_match_memwb) begin
      o_value = i_memwb_rd_data;
    end else if (w_rs_nonzero) begin
      o_value = i_rf_data;
    end
  end
`else
  logic w_unused_fwd_data;
  assign w_unused_fwd_data = ^{i_exmem_rd_data, i_memwb_rd_data};

  assign o_value = w_rs_nonzero ? i_rf_data : '0;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX boundary register feeding alu_module.
// Selects operand A (rs1/PC) and B (rs2/imm), resolves RAW hazards by forwarding or
// stalling, and holds op/A/B/rd/rd_we stable for the EX stage.
// Ports:
//   clk, reset_n (synchronous, active low), flush (drop held and incoming instruction)
//   in_valid/in_ready + decoded instruction fields     upstream handshake
//   exmem_*, memwb_*                                   producer candidates for forwarding
//   out_valid/out_ready + out_alu_op/a/b/rd_addr/rd_we downstream handshake
//   stall_count                                        saturating hazard-stall cycle count
// Macro OPERAND_FORWARDING_EN: defined -> forward, stall only on load-use;
// undefined -> no forwarding, stall on any match with EX/MEM or MEM/WB.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN       = DefXlen,
  parameter int unsigned REG_ADDR_W = DefRegAddrW,
  parameter int unsigned ALU_OP_W   = DefAluOpW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_W-1:0]   in_alu_op,
  input  logic                  in_a_sel,
  input  logic                  in_b_sel,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic                  in_rs2_used,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_we,
  input  logic                  exmem_rd_we,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]       exmem_rd_data,
  input  logic                  exmem_is_load,
  input  logic                  memwb_rd_we,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]       memwb_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_OP_W-1:0]   out_alu_op,
  output logic [XLEN-1:0]       out_a,
  output logic [XLEN-1:0]       out_b,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_rd_we,
  output logic [31:0]           stall_count
);

  logic                  r_valid;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic [XLEN-1:0]       r_a;
  logic [XLEN-1:0]       r_b;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_we;
  logic [31:0]           r_stall_count;

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_rs1_ex;
  logic            w_rs1_wb;
  logic            w_rs2_ex;
  logic            w_rs2_wb;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_hazard;
  logic            w_xfer;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;

  operand_forward_mux #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .i_rs_addr       (in_rs1_addr),
    .i_rf_data       (in_rs1_data),
    .i_exmem_rd_we   (exmem_rd_we),
    .i_exmem_rd_addr (exmem_rd_addr),
    .i_exmem_rd_data (exmem_rd_data),
    .i_memwb_rd_we   (memwb_rd_we),
    .i_memwb_rd_addr (memwb_rd_addr),
    .i_memwb_rd_data (memwb_rd_data),
    .o_value         (w_rs1_val),
    .o_match_exmem   (w_rs1_ex),
    .o_match_memwb   (w_rs1_wb)
  );

  operand_forward_mux #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .i_rs_addr       (in_rs2_addr),
    .i_rf_data       (in_rs2_data),
    .i_exmem_rd_we   (exmem_rd_we),
    .i_exmem_rd_addr (exmem_rd_addr),
    .i_exmem_rd_data (exmem_rd_data),
    .i_memwb_rd_we   (memwb_rd_we),
    .i_memwb_rd_addr (memwb_rd_addr),
    .i_memwb_rd_data (memwb_rd_data),
    .o_value         (w_rs2_val),
    .o_match_exmem   (w_rs2_ex),
    .o_match_memwb   (w_rs2_wb)
  );

  // rs2 is a real source for stores/branches even when B carries the immediate.
  assign w_rs1_used = (in_a_sel == OpSelARs1);
  assign w_rs2_used = (in_b_sel == OpSelBRs2) | in_rs2_used;

`ifdef OPERAND_FORWARDING_EN
  logic w_unused_wb_match;
  assign w_unused_wb_match = w_rs1_wb ^ w_rs2_wb;

  // Only a load in EX/MEM cannot be forwarded yet.
  assign w_hazard = exmem_is_load & ((w_rs1_used & w_rs1_ex) | (w_rs2_used & w_rs2_ex));
`else
  logic w_unused_is_load;
  assign w_unused_is_load = exmem_is_load;

  assign w_hazard = (w_rs1_used & (w_rs1_ex | w_rs1_wb)) |
                    (w_rs2_used & (w_rs2_ex | w_rs2_wb));
`endif

  assign w_a = (in_a_sel == OpSelAPc)  ? in_pc  : w_rs1_val;
  assign w_b = (in_b_sel == OpSelBImm) ? in_imm : w_rs2_val;

  always_comb begin
    in_ready = reset_n & (~r_valid | out_ready) & ~w_hazard & ~flush;
    w_xfer   = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_alu_op  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rd_addr <= '0;
      r_rd_we   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid   <= 1'b1;
      r_alu_op  <= in_alu_op;
      r_a       <= w_a;
      r_b       <= w_b;
      r_rd_addr <= in_rd_addr;
      r_rd_we   <= in_rd_we;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (in_valid & w_hazard & ~flush) begin
      r_stall_count <= sat_inc(r_stall_count);
    end
  end

  assign out_valid   = r_valid;
  assign out_alu_op  = r_alu_op;
  assign out_a       = r_a;
  assign out_b       = r_b;
  assign out_rd_addr = r_rd_addr;
  assign out_rd_we   = r_rd_we;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage. Follows OPERAND_FORWARDING_EN like the design.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready;
  logic [3:0]  in_alu_op;
  logic        in_a_sel, in_b_sel, in_rs2_used, in_rd_we;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic        exmem_rd_we, exmem_is_load, memwb_rd_we;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_rd_data, memwb_rd_data;
  logic        out_valid, out_ready, out_rd_we;
  logic [3:0]  out_alu_op;
  logic [31:0] out_a, out_b, stall_count;
  logic [4:0]  out_rd_addr;

  always #5 clk = ~clk;

  alu_operand_stage u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_a_sel      (in_a_sel),
    .in_b_sel      (in_b_sel),
    .in_rs1_addr   (in_rs1_addr),
    .in_rs2_addr   (in_rs2_addr),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_rs2_used   (in_rs2_used),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rd_addr    (in_rd_addr),
    .in_rd_we      (in_rd_we),
    .exmem_rd_we   (exmem_rd_we),
    .exmem_rd_addr (exmem_rd_addr),
    .exmem_rd_data (exmem_rd_data),
    .exmem_is_load (exmem_is_load),
    .memwb_rd_we   (memwb_rd_we),
    .memwb_rd_addr (memwb_rd_addr),
    .memwb_rd_data (memwb_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_op    (out_alu_op),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_rd_addr   (out_rd_addr),
    .out_rd_we     (out_rd_we),
    .stall_count   (stall_count)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_stall;
  logic        m_zero;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_opnd(input logic [4:0] ra, input logic [31:0] rf,
                                           output logic mex, output logic mwb);
    mex = (ra != 5'd0) && exmem_rd_we && (ra == exmem_rd_addr);
    mwb = (ra != 5'd0) && memwb_rd_we && (ra == memwb_rd_addr);
`ifdef OPERAND_FORWARDING_EN
    if (mex) return exmem_rd_data;
    if (mwb) return memwb_rd_data;
`endif
    return (ra == 5'd0) ? 32'd0 : rf;
  endfunction

  function automatic void ref_model(output logic hz, output exp_t e);
    logic m1e, m1w, m2e, m2w, u1, u2;
    logic [31:0] v1, v2;
    v1 = ref_opnd(in_rs1_addr, in_rs1_data, m1e, m1w);
    v2 = ref_opnd(in_rs2_addr, in_rs2_data, m2e, m2w);
    u1 = !in_a_sel;
    u2 = !in_b_sel || in_rs2_used;
`ifdef OPERAND_FORWARDING_EN
    hz = exmem_is_load && ((u1 && m1e) || (u2 && m2e));
`else
    hz = (u1 && (m1e || m1w)) || (u2 && (m2e || m2w));
`endif
    e.op = in_alu_op;
    e.a  = in_a_sel ? in_pc : v1;
    e.b  = in_b_sel ? in_imm : v2;
    e.rd = in_rd_addr;
    e.we = in_rd_we;
  endfunction

  // Check at negedge, advance the model at posedge, leave inputs free to change at +1.
  task automatic cycle();
    logic hz, rdy;
    exp_t e;
    @(negedge clk);
    ref_model(hz, e);
    rdy = reset_n && (exp_q.size() == 0 || out_ready) && !hz && !flush;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    check("stall_count", stall_count, m_stall);
    if (exp_q.size() != 0) begin
      check("out_alu_op", {28'd0, out_alu_op}, {28'd0, exp_q[0].op});
      check("out_a", out_a, exp_q[0].a);
      check("out_b", out_b, exp_q[0].b);
      check("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, exp_q[0].rd});
      check("out_rd_we", {31'd0, out_rd_we}, {31'd0, exp_q[0].we});
    end else if (m_zero) begin
      check("out_a_zero", out_a, 32'd0);
      check("out_b_zero", out_b, 32'd0);
    end
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      m_stall = 32'd0;
      m_zero  = 1'b1;
    end else begin
      if (in_valid && hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && rdy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(e);
        m_zero = 1'b0;
      end else if (out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 1; in_alu_op = 4'd0;
    in_a_sel = 0; in_b_sel = 0; in_rs2_used = 0; in_rd_we = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_pc = 0; in_imm = 0;
    exmem_rd_we = 0; exmem_is_load = 0; exmem_rd_addr = 0; exmem_rd_data = 0;
    memwb_rd_we = 0; memwb_rd_addr = 0; memwb_rd_data = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic asel, input logic bsel,
                       input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_valid = 1; in_alu_op = op; in_a_sel = asel; in_b_sel = bsel;
    in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
    in_pc = 32'h0000_1000; in_imm = imm; in_rd_addr = rd; in_rd_we = 1;
  endtask

  logic [31:0] s0;

  initial begin
    idle();
    reset_n = 0;
    in_valid = 1;
    m_stall = 0;
    m_zero = 1;
    @(posedge clk);
    #1;
    // 1: reset held with a valid input presented
    cycle();
    cycle();
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_in_ready", {31'd0, in_ready}, 32'd0);

    // 2: ADD x5(10) + imm 7, no producers
    idle();
    reset_n = 1;
    instr(AluAdd, OpSelARs1, OpSelBImm, 5'd5, 32'd10, 5'd0, 32'd0, 32'd7, 5'd1);
    cycle();
    check("t2_out_a", out_a, 32'd10);
    check("t2_out_b", out_b, 32'd7);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    idle();
    cycle();

    // 3: EX/MEM wins over MEM/WB; x0 reads zero
    instr(AluOr, OpSelARs1, OpSelBImm, 5'd3, 32'd1, 5'd0, 32'd0, 32'd0, 5'd2);
    exmem_rd_we = 1; exmem_rd_addr = 5'd3; exmem_rd_data = 32'h22;
    memwb_rd_we = 1; memwb_rd_addr = 5'd3; memwb_rd_data = 32'h33;
    cycle();
`ifdef OPERAND_FORWARDING_EN
    check("t3_fwd_exmem", out_a, 32'h22);
`else
    check("t3_stall", {31'd0, out_valid}, 32'd0);
`endif
    in_rs1_addr = 5'd0;
    cycle();
    check("t3_x0", out_a, 32'd0);
    idle();
    cycle();

    // 4: load-use on rs2 for two cycles, then MEM/WB supplies it
    s0 = m_stall;
    instr(AluSub, OpSelARs1, OpSelBRs2, 5'd0, 32'd0, 5'd4, 32'h4, 32'd0, 5'd7);
    exmem_rd_we = 1; exmem_rd_addr = 5'd4; exmem_rd_data = 32'hDEAD; exmem_is_load = 1;
    cycle();
    cycle();
    check("t4_stall2", stall_count, s0 + 32'd2);
    exmem_rd_we = 0; exmem_is_load = 0;
    memwb_rd_we = 1; memwb_rd_addr = 5'd4; memwb_rd_data = 32'h44;
    cycle();
`ifdef OPERAND_FORWARDING_EN
    check("t4_out_b", out_b, 32'h44);
`else
    check("t4_nofwd_stall", {31'd0, out_valid}, 32'd0);
`endif
    idle();
    cycle();

    // 5: backpressure holds outputs, then flush drops everything
    out_ready = 0;
    instr(AluXor, OpSelAPc, OpSelBImm, 5'd0, 32'd0, 5'd0, 32'd0, 32'h55, 5'd9);
    cycle();
    instr(AluAnd, OpSelAPc, OpSelBImm, 5'd0, 32'd0, 5'd0, 32'd0, 32'h66, 5'd10);
    for (int i = 0; i < 3; i++) cycle();
    check("t5_held_b", out_b, 32'h55);
    flush = 1;
    cycle();
    check("t5_flushed", {31'd0, out_valid}, 32'd0);
    idle();
    cycle();

    // 6: non-load MEM/WB match on rs1
    instr(AluAdd, OpSelARs1, OpSelBImm, 5'd6, 32'h66, 5'd0, 32'd0, 32'd0, 5'd11);
    memwb_rd_we = 1; memwb_rd_addr = 5'd6; memwb_rd_data = 32'h99;
    cycle();
`ifdef OPERAND_FORWARDING_EN
    check("t6_fwd", out_a, 32'h99);
`else
    check("t6_stall", {31'd0, out_valid}, 32'd0);
    memwb_rd_we = 0;
    cycle();
    check("t6_rf", out_a, 32'h66);
`endif
    idle();
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset_n       = ($urandom_range(63) != 0);
      flush         = ($urandom_range(15) == 0);
      in_valid      = ($urandom_range(3) != 0);
      out_ready     = ($urandom_range(3) != 0);
      in_alu_op     = 4'($urandom_range(9));
      in_a_sel      = 1'($urandom_range(1));
      in_b_sel      = 1'($urandom_range(1));
      in_rs2_used   = 1'($urandom_range(1));
      in_rs1_addr   = 5'($urandom_range(7));
      in_rs2_addr   = 5'($urandom_range(7));
      in_rd_addr    = 5'($urandom_range(31));
      in_rd_we      = 1'($urandom_range(1));
      in_rs1_data   = $urandom;
      in_rs2_data   = $urandom;
      in_pc         = $urandom;
      in_imm        = $urandom;
      exmem_rd_we   = 1'($urandom_range(1));
      exmem_rd_addr = 5'($urandom_range(7));
      exmem_rd_data = $urandom;
      exmem_is_load = ($urandom_range(3) == 0);
      memwb_rd_we   = 1'($urandom_range(1));
      memwb_rd_addr = 5'($urandom_range(7));
      memwb_rd_data = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
